// File: rtl/zmips_muldiv_ctrl.sv
// Multi-cycle MULTU/DIVU sequencer sharing the execute-stage ALU, one add/sub per cycle.
// Optional immediate divide-by-zero completion when ZMIPS_MULDIV_DIV0_EN is defined.
module zmips_muldiv_ctrl #(
  parameter int unsigned ZERO_SKIP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op_div,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div0,
  output logic        alu_sel,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  output logic        alu_cin,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_y,
  input  logic        alu_cout
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic        div0_q, div0_d;
  logic        accept, mul_zero;
  logic [31:0] div_p;

  assign busy      = (state_q == StMul) || (state_q == StDiv);
  assign done      = (state_q == StDone);
  assign alu_sel   = busy;
  assign alu_shamt = 5'd0;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign div0      = div0_q;

  assign accept   = start & ~busy;
  assign mul_zero = (ZERO_SKIP != 0) && ((rs_val == 32'd0) || (rt_val == 32'd0));
  // Restoring-division partial remainder: hi shifted left, next dividend bit from lo.
  assign div_p    = {hi_q[30:0], lo_q[31]};

  always_comb begin
    alu_a   = 32'd0;
    alu_b   = 32'd0;
    alu_op  = 4'h0;
    alu_cin = 1'b0;
    unique case (state_q)
      StMul: begin
        alu_a = hi_q;
        alu_b = opnd_q;
      end
      StDiv: begin
        alu_a   = div_p;
        alu_b   = opnd_q;
        alu_op  = 4'h1;
        alu_cin = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    div0_d  = div0_q;
    unique case (state_q)
      StMul: begin
        if (lo_q[0]) {hi_d, lo_d} = {alu_cout, alu_y, lo_q[31:1]};
        else         {hi_d, lo_d} = {1'b0, hi_q, lo_q[31:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = StDone;
      end
      StDiv: begin
        // hi[31] set means the shifted remainder exceeds 32 bits, so it always fits.
        if (hi_q[31] | alu_cout) begin
          hi_d = alu_y;
          lo_d = {lo_q[30:0], 1'b1};
        end else begin
          hi_d = div_p;
          lo_d = {lo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: ;
    endcase

    if (accept) begin
      opnd_d = rt_val;
      cnt_d  = 5'd0;
      hi_d   = 32'd0;
      lo_d   = rs_val;
      div0_d = 1'b0;
      if (!op_div) begin
        if (mul_zero) begin
          lo_d    = 32'd0;
          state_d = StDone;
        end else begin
          state_d = StMul;
        end
      end else begin
        state_d = StDiv;
`ifdef ZMIPS_MULDIV_DIV0_EN
        if (rt_val == 32'd0) begin
          hi_d    = rs_val;
          lo_d    = 32'hFFFF_FFFF;
          div0_d  = 1'b1;
          state_d = StDone;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 5'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      opnd_q  <= 32'd0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      div0_q  <= div0_d;
    end
  end

endmodule

// File: tb/tb_zmips_muldiv_ctrl.sv
// Directed bench for zmips_muldiv_ctrl: vector table plus multi-cycle corner sequences.
module tb_zmips_muldiv_ctrl;

`ifdef ZMIPS_MULDIV_DIV0_EN
  localparam bit Div0En = 1'b1;
`else
  localparam bit Div0En = 1'b0;
`endif

  typedef struct {
    logic        op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    logic        d0;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        op_div = 1'b0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        dut_sel = 1'b0;
  int          n_cmp = 0;
  int          n_fail = 0;

  logic        busy_a, done_a, div0_a, sel_a, cin_a, cout_a, busy_b, done_b, div0_b, sel_b;
  logic        cin_b, cout_b;
  logic [31:0] hi_a, lo_a, a_a, b_a, y_a, hi_b, lo_b, a_b, b_b, y_b;
  logic [3:0]  op_a, op_b;
  logic [4:0]  sh_a, sh_b;

  logic        busy_m, done_m, div0_m, sel_m, cin_m;
  logic [31:0] hi_m, lo_m, a_m, b_m;
  logic [3:0]  op_m;
  logic [4:0]  sh_m;

  always #5 clk = ~clk;

  // Reference ALU: ADD or SUB (B inverted) with carry in.
  assign {cout_a, y_a} = {1'b0, a_a} + {1'b0, (op_a == 4'h1) ? ~b_a : b_a} + {32'd0, cin_a};
  assign {cout_b, y_b} = {1'b0, a_b} + {1'b0, (op_b == 4'h1) ? ~b_b : b_b} + {32'd0, cin_b};

  zmips_muldiv_ctrl #(.ZERO_SKIP(1)) u_dut_a (
    .clk(clk), .rst(rst), .start(start & ~dut_sel), .op_div(op_div), .rs_val(rs_val),
    .rt_val(rt_val), .busy(busy_a), .done(done_a), .hi(hi_a), .lo(lo_a), .div0(div0_a),
    .alu_sel(sel_a), .alu_a(a_a), .alu_b(b_a), .alu_op(op_a), .alu_cin(cin_a),
    .alu_shamt(sh_a), .alu_y(y_a), .alu_cout(cout_a)
  );

  zmips_muldiv_ctrl #(.ZERO_SKIP(0)) u_dut_b (
    .clk(clk), .rst(rst), .start(start & dut_sel), .op_div(op_div), .rs_val(rs_val),
    .rt_val(rt_val), .busy(busy_b), .done(done_b), .hi(hi_b), .lo(lo_b), .div0(div0_b),
    .alu_sel(sel_b), .alu_a(a_b), .alu_b(b_b), .alu_op(op_b), .alu_cin(cin_b),
    .alu_shamt(sh_b), .alu_y(y_b), .alu_cout(cout_b)
  );

  assign busy_m = dut_sel ? busy_b : busy_a;
  assign done_m = dut_sel ? done_b : done_a;
  assign div0_m = dut_sel ? div0_b : div0_a;
  assign sel_m  = dut_sel ? sel_b  : sel_a;
  assign cin_m  = dut_sel ? cin_b  : cin_a;
  assign hi_m   = dut_sel ? hi_b   : hi_a;
  assign lo_m   = dut_sel ? lo_b   : lo_a;
  assign a_m    = dut_sel ? a_b    : a_a;
  assign b_m    = dut_sel ? b_b    : b_a;
  assign op_m   = dut_sel ? op_b   : op_a;
  assign sh_m   = dut_sel ? sh_b   : sh_a;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  task automatic run_vec(input vec_t v, input int pulse_at, input string name);
    int k;
    int busy_cnt;
    int sel_bad;
    bit got;
    @(negedge clk);
    op_div = v.op; rs_val = v.rs; rt_val = v.rt; start = 1'b1;
    @(negedge clk);
    start = 1'b0; k = 1; got = 1'b0; busy_cnt = 0; sel_bad = 0;
    while (!got && k <= 40) begin
      if (sel_m !== busy_m || sh_m !== 5'd0) sel_bad++;
      if (busy_m === 1'b1) busy_cnt++;
      if (done_m === 1'b1) begin
        got = 1'b1;
      end else begin
        start = (pulse_at != 0) && (k == pulse_at);
        if (start) begin
          op_div = 1'b1; rs_val = 32'd100; rt_val = 32'd7;
        end
        @(negedge clk);
        k++;
      end
    end
    start = 1'b0;
    check({name, " done seen"}, 64'(got), 64'd1);
    if (got) check({name, " latency"}, 64'(k), 64'(v.lat));
    check({name, " hi"}, {32'd0, hi_m}, {32'd0, v.hi});
    check({name, " lo"}, {32'd0, lo_m}, {32'd0, v.lo});
    check({name, " div0"}, 64'(div0_m), 64'(v.d0));
    check({name, " busy cycles"}, 64'(busy_cnt), 64'(v.lat - 1));
    check({name, " alu_sel/shamt"}, 64'(sel_bad), 64'd0);
    @(negedge clk);
    check({name, " done pulse width"}, 64'(done_m), 64'd0);
    check({name, " hold"}, {hi_m, lo_m}, {v.hi, v.lo});
    check({name, " idle alu"}, {a_m, b_m}, 64'd0);
    check({name, " idle alu op/cin"}, {59'd0, op_m, cin_m}, 64'd0);
  endtask

  task automatic wait_done(output int k);
    k = 1;
    while (done_m !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
  endtask

  vec_t vecs[13];

  initial begin
    int k;
    bit seen;
    vecs[0]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 1'b0};
    vecs[1]  = '{1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b0};
    vecs[2]  = '{1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 33, 1'b0};
    vecs[3]  = '{1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, Div0En ? 1 : 33, Div0En};
    vecs[4]  = '{1'b0, 32'd0, 32'h1234, 32'd0, 32'd0, 1, 1'b0};
    vecs[5]  = '{1'b0, 32'd3, 32'd5, 32'd0, 32'd15, 33, 1'b0};
    vecs[6]  = '{1'b0, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 33, 1'b0};
    vecs[7]  = '{1'b0, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, 33, 1'b0};
    vecs[8]  = '{1'b1, 32'h8000_0000, 32'd3, 32'd2, 32'h2AAA_AAAA, 33, 1'b0};
    vecs[9]  = '{1'b1, 32'd7, 32'd100, 32'd7, 32'd0, 33, 1'b0};
    vecs[10] = '{1'b0, 32'h1234_5678, 32'd0, 32'd0, 32'd0, 1, 1'b0};
    vecs[11] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 33, 1'b0};
    vecs[12] = '{1'b1, 32'd0, 32'd5, 32'd0, 32'd0, 33, 1'b0};

    repeat (3) @(negedge clk);
    check("reset state", {busy_a, done_a, div0_a, sel_a, cin_a, op_a, hi_a, lo_a},
          {9'd0, 32'd0, 32'd0});
    check("reset alu operands", {a_a, b_a}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(vecs[i], 0, $sformatf("vec%0d", i));

    // Start pulsed mid-MULTU must be ignored.
    run_vec(vecs[5], 5, "busy start ignored");

    // No zero skip: MULTU by zero takes the full path.
    dut_sel = 1'b1;
    run_vec('{1'b0, 32'd0, 32'h1234, 32'd0, 32'd0, 33, 1'b0}, 0, "noskip mul0");
    dut_sel = 1'b0;

    // Back-to-back: new start accepted in the DONE cycle.
    @(negedge clk);
    op_div = 1'b0; rs_val = 32'd6; rt_val = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(k);
    check("b2b first latency", 64'(k), 64'd33);
    check("b2b first lo", {32'd0, lo_m}, 64'd42);
    op_div = 1'b1; rs_val = 32'd100; rt_val = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b accepted", {62'd0, busy_m, done_m}, 64'd2);
    wait_done(k);
    check("b2b second latency", 64'(k), 64'd33);
    check("b2b second result", {hi_m, lo_m}, {32'd2, 32'd14});

    // Reset mid-DIVU aborts with no done pulse.
    @(negedge clk);
    op_div = 1'b1; rs_val = 32'd100; rt_val = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst abort flags", {61'd0, busy_a, sel_a, done_a}, 64'd0);
    check("rst abort hi/lo", {hi_a, lo_a}, 64'd0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done_a === 1'b1) seen = 1'b1;
    end
    check("rst no done", 64'(seen), 64'd0);
    run_vec('{1'b0, 32'd6, 32'd7, 32'd0, 32'd42, 33, 1'b0}, 0, "after rst mul");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
